// File: rtl/crc5_frame_checker.sv
// Receive-side CRC-5 frame checker: forwards payload bytes, recomputes the CRC
// over at most MAX_LEN payload bytes and reports a per-frame verdict plus counters.
module crc5_frame_checker #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             len_err,
  output logic             fmt_err,
  output logic [4:0]       crc_calc,
  output logic [LEN_W-1:0] frame_len,
  output logic [CNT_W-1:0] frames_good,
  output logic [CNT_W-1:0] frames_bad
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN, CHECK} state_t;

  localparam logic [4:0]       CRC_INIT = 5'h1F;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  state_t           state_reg, state_next;
  logic [4:0]       crc_reg, crc_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             ovf_reg, ovf_next;
  logic [7:0]       trailer_reg, trailer_next;
  logic             fwd, finish, accept;
  logic             fmt_bad, verdict_ok;

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] n;
    n[0] = c[0] ^ c[2] ^ c[3] ^ d[0] ^ d[3] ^ d[5] ^ d[6];
    n[1] = c[1] ^ c[3] ^ c[4] ^ d[1] ^ d[4] ^ d[6] ^ d[7];
    n[2] = c[0] ^ c[3] ^ c[4] ^ d[0] ^ d[2] ^ d[3] ^ d[6] ^ d[7];
    n[3] = c[0] ^ c[1] ^ c[4] ^ d[1] ^ d[3] ^ d[4] ^ d[7];
    n[4] = c[1] ^ c[2] ^ d[2] ^ d[4] ^ d[5];
    return n;
  endfunction

  assign in_ready   = (state_reg != CHECK);
  assign accept     = in_valid && in_ready;
  assign fmt_bad    = |trailer_reg[7:5];
  assign verdict_ok = (trailer_reg[4:0] == crc_reg) && !ovf_reg && !fmt_bad;

  always_comb begin
    state_next   = state_reg;
    crc_next     = crc_reg;
    len_next     = len_reg;
    ovf_next     = ovf_reg;
    trailer_next = trailer_reg;
    fwd          = 1'b0;
    finish       = 1'b0;
    case (state_reg)
      // IDLE always has len=0, so it shares the payload path.
      IDLE, PAYLOAD: begin
        if (accept) begin
          if (in_last) begin
            trailer_next = in_data;
            state_next   = CHECK;
          end else if (len_reg < LEN_MAX) begin
            crc_next   = crc5_step(crc_reg, in_data);
            len_next   = len_reg + 1'b1;
            fwd        = 1'b1;
            state_next = PAYLOAD;
          end else begin
            ovf_next   = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          trailer_next = in_data;
          state_next   = CHECK;
        end
      end
      CHECK: begin
        finish     = 1'b1;
        crc_next   = CRC_INIT;
        len_next   = '0;
        ovf_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg   <= IDLE;
      crc_reg     <= CRC_INIT;
      len_reg     <= '0;
      ovf_reg     <= 1'b0;
      trailer_reg <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      len_err     <= 1'b0;
      fmt_err     <= 1'b0;
      crc_calc    <= '0;
      frame_len   <= '0;
      frames_good <= '0;
      frames_bad  <= '0;
    end else begin
      state_reg   <= state_next;
      crc_reg     <= crc_next;
      len_reg     <= len_next;
      ovf_reg     <= ovf_next;
      trailer_reg <= trailer_next;
      out_valid   <= fwd;
      frame_done  <= finish;
      if (fwd) out_data <= in_data;
      if (finish) begin
        crc_ok    <= verdict_ok;
        len_err   <= ovf_reg;
        fmt_err   <= fmt_bad;
        crc_calc  <= crc_reg;
        frame_len <= len_reg;
        if (verdict_ok) begin
          if (frames_good != '1) frames_good <= frames_good + 1'b1;
        end else begin
          if (frames_bad != '1) frames_bad <= frames_bad + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc5_frame_checker.sv
// Scoreboard bench for crc5_frame_checker: a frame-level model queues expected
// bytes and verdicts on acceptance; a monitor pops and compares DUT outputs.
module tb_crc5_frame_checker;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam int CNT_W   = 16;

  logic             ck = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             frame_done;
  logic             crc_ok;
  logic             len_err;
  logic             fmt_err;
  logic [4:0]       crc_calc;
  logic [LEN_W-1:0] frame_len;
  logic [CNT_W-1:0] frames_good;
  logic [CNT_W-1:0] frames_bad;

  always #5 ck = ~ck;

  crc5_frame_checker #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .frame_done(frame_done), .crc_ok(crc_ok), .len_err(len_err), .fmt_err(fmt_err),
    .crc_calc(crc_calc), .frame_len(frame_len), .frames_good(frames_good),
    .frames_bad(frames_bad)
  );

  typedef struct {
    bit       ok;
    bit       le;
    bit       fe;
    int       crc;
    int       len;
    int       good;
    int       bad;
  } verdict_t;

  verdict_t   exp_v[$];
  logic [7:0] exp_b[$];
  int checks = 0;
  int errors = 0;
  int trailers = 0;
  int low_cycles = 0;

  // Each next-CRC bit is the parity of {data, crc} under a fixed tap mask.
  localparam logic [12:0] TAPS [5] = '{
    {8'h69, 5'h0D}, {8'hD2, 5'h1A}, {8'hCD, 5'h19}, {8'h9A, 5'h13}, {8'h34, 5'h06}
  };

  logic [4:0] m_crc;
  int         m_len;
  bit         m_ovf;
  int         m_good;
  int         m_bad;

  function automatic logic [4:0] model_step(input logic [4:0] c, input logic [7:0] d);
    logic [12:0] v;
    logic [4:0]  r;
    v = {d, c};
    for (int i = 0; i < 5; i++) r[i] = ^(v & TAPS[i]);
    return r;
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_clear_frame();
    m_crc = 5'h1F;
    m_len = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input bit l);
    verdict_t v;
    if (l) begin
      v.fe  = (d[7:5] != 3'b000);
      v.le  = m_ovf;
      v.crc = m_crc;
      v.len = m_len;
      v.ok  = (d[4:0] == m_crc) && !m_ovf && !v.fe;
      if (v.ok) m_good = (m_good == (1 << CNT_W) - 1) ? m_good : m_good + 1;
      else      m_bad  = (m_bad  == (1 << CNT_W) - 1) ? m_bad  : m_bad + 1;
      v.good = m_good;
      v.bad  = m_bad;
      exp_v.push_back(v);
      trailers++;
      $display("frame: len=%0d crc=%h trailer=%h ok=%0d len_err=%0d fmt_err=%0d",
               v.len, v.crc, d, v.ok, v.le, v.fe);
      model_clear_frame();
    end else if (!m_ovf) begin
      if (m_len < MAX_LEN) begin
        exp_b.push_back(d);
        m_crc = model_step(m_crc, d);
        m_len++;
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send(input logic [7:0] d, input bit l);
    int waitc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && waitc < 8) begin
      @(negedge ck);
      waitc++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      @(negedge ck);
      model_accept(d, l);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic random_frame(input int n, input bit gaps);
    logic [7:0] t;
    int         kind;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge ck);
      send(8'($urandom), 1'b0);
    end
    kind = $urandom_range(0, 7);
    t = {3'b000, m_crc};
    if (kind == 0) t = 8'($urandom);
    else if (kind == 1) t[$urandom_range(0, 4)] = ~t[$urandom_range(0, 4)] ^ 1'b0;
    else if (kind == 2) t[5 + $urandom_range(0, 2)] = 1'b1;
    if (gaps && $urandom_range(0, 3) == 0) @(negedge ck);
    send(t, 1'b1);
  endtask

  // Monitor: sample 1 time unit after negedge so same-edge model pushes are visible.
  initial begin
    bit       prev_low;
    verdict_t v;
    prev_low = 0;
    forever begin
      @(negedge ck);
      #1;
      if (out_valid === 1'b1) begin
        if (exp_b.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("out_data", int'(out_data), int'(exp_b.pop_front()));
      end
      if (frame_done === 1'b1) begin
        if (exp_v.size() == 0) begin
          check("spurious_frame_done", 1, 0);
        end else begin
          v = exp_v.pop_front();
          check("crc_ok", int'(crc_ok), int'(v.ok));
          check("len_err", int'(len_err), int'(v.le));
          check("fmt_err", int'(fmt_err), int'(v.fe));
          check("crc_calc", int'(crc_calc), v.crc);
          check("frame_len", int'(frame_len), v.len);
          check("frames_good", int'(frames_good), v.good);
          check("frames_bad", int'(frames_bad), v.bad);
        end
      end
      if (in_ready === 1'b0) begin
        low_cycles++;
        if (prev_low) check("in_ready_low_run", 2, 1);
        prev_low = 1;
      end else begin
        prev_low = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    m_good = 0;
    m_bad = 0;
    model_clear_frame();
    repeat (3) @(negedge ck);
    rst = 1'b0;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_crc_ok", int'(crc_ok), 0);
    check("reset_crc_calc", int'(crc_calc), 0);
    check("reset_frame_len", int'(frame_len), 0);
    check("reset_frames_good", int'(frames_good), 0);
    check("reset_frames_bad", int'(frames_bad), 0);

    // Directed frames: good one-byte, bad one-byte, trailer-only good / format error.
    send(8'h00, 1'b0); send(8'h0F, 1'b1);
    send(8'h00, 1'b0); send(8'h0E, 1'b1);
    send(8'h1F, 1'b1);
    send(8'h3F, 1'b1);

    // Oversized frame with a trailer carrying the CRC of the kept bytes.
    for (int i = 0; i < MAX_LEN + 3; i++) send(8'($urandom), 1'b0);
    send({3'b000, m_crc}, 1'b1);

    // Random frames, with and without input gaps, including zero-length.
    for (int f = 0; f < 40; f++) random_frame($urandom_range(0, 12), f[0]);

    // Abandon a frame with reset, then one clean frame.
    send(8'hA5, 1'b0); send(8'h5A, 1'b0); send(8'h3C, 1'b0);
    @(negedge ck);
    rst = 1'b1;
    repeat (2) @(negedge ck);
    rst = 1'b0;
    m_good = 0;
    m_bad = 0;
    model_clear_frame();
    check("midreset_frames_good", int'(frames_good), 0);
    check("midreset_frames_bad", int'(frames_bad), 0);
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
    send({3'b000, m_crc}, 1'b1);

    repeat (6) @(negedge ck);
    #2;
    check("bytes_outstanding", exp_b.size(), 0);
    check("verdicts_outstanding", exp_v.size(), 0);
    check("in_ready_low_cycles", low_cycles, trailers);
    check("final_frames_good", int'(frames_good), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
